serial_word_deserializer: RTL and testbench
===========================================

// Module: serial_word_deserializer
// PURPOSE
// - Collects a 1-bit serial stream into WIDTH-bit parallel words.
// - Sits directly upstream of the bit population counter. data_o/data_val_o drive its data_i/data_val_i.
// - Downstream is always ready, so there is no backpressure.
// - Optionally flushes a partial word, zero-padded so the downstream popcount is unaffected.
// PARAMETERS
// - WIDTH      32  output word width, >= 2; matches the downstream counter's WIDTH
// - MSB_FIRST  1   1: first serial bit lands in data_o[WIDTH-1]; 0: first bit lands in data_o[0]
// PORTS
// - clk_i       in   1                  clock; one clock domain
// - arst_i      in   1                  reset; asynchronous, active-high
// - data_i      in   1                  serial data bit
// - data_val_i  in   1                  data_i valid; bit accepted on each clk_i edge where high
// - flush_i     in   1                  emit partial word; ignored without DESER_FLUSH_EN
// - data_o      out  WIDTH              assembled word
// - data_mod_o  out  $clog2(WIDTH)+1    number of serial bits in data_o (1..WIDTH)
// - data_val_o  out  1                  one-cycle pulse: data_o/data_mod_o valid
// - busy_o      out  1                  partial word held (bit count != 0)
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high.
// - Reset values: data_o=0, data_mod_o=0, data_val_o=0, busy_o=0, bit count=0, shift reg=0, FSM=IDLE.
// - Reset mid-word: the partial word is discarded, with no output. Reset during a data_val_o pulse kills the pulse.
// - FSM states:
//   - IDLE: count==0. data_val_i -> COLLECT, count=1.
//   - COLLECT: each data_val_i increments count. When the WIDTH-th bit is accepted -> emit and return to count 0 / IDLE.
// - Latency: data_val_o rises on the clock edge that accepts the word's last bit. Visible 1 cycle after it was driven on data_i.
// - data_val_o is high for exactly 1 cycle per word.
// - data_o and data_mod_o hold their last emitted value until the next emit; they never show partial contents.
// - Back-to-back: a bit accepted in the same cycle data_val_o is high starts the next word (count=1). Full rate is 1 word per WIDTH cycles, with no bubble.
// - Gaps: data_val_i low holds count and shift reg indefinitely. No timeout.
// - Bit placement for the k-th accepted bit (k=0..WIDTH-1):
//   - MSB_FIRST=1: lands in data_o[WIDTH-1-k].
//   - MSB_FIRST=0: lands in data_o[k].
// - Unfilled positions are always 0.
// - data_mod_o = WIDTH for full words. Width $clog2(WIDTH)+1 holds WIDTH even when WIDTH is a power of 2.
// - busy_o is registered and equals (count != 0) after each edge.
// CONFIGURATION
// - DESER_FLUSH_EN defined:
//   - flush_i high with count>0, or with data_val_i high in the same cycle, emits the partial word on that edge.
//   - The partial word includes any bit accepted that cycle.
//   - data_mod_o = bits held. Unfilled bits are zero, using the MSB_FIRST placement above.
//   - After a flush, count=0 and the FSM is IDLE.
//   - flush_i with count==0 and no data_val_i: ignored, no pulse.
//   - flush_i in the same cycle as the WIDTH-th bit: one normal full-word emit only.
// - DESER_FLUSH_EN undefined:
//   - The flush_i port is still present and is ignored.
//   - data_mod_o is constant WIDTH after the first emit (0 after reset).
// TESTING (WIDTH=8)
// - MSB_FIRST=1, serial 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> one pulse, data_o=8'hB2, data_mod_o=8, busy_o low after.
// - MSB_FIRST=0, same stream -> data_o=8'h4D. 24 back-to-back bits -> 3 pulses exactly 8 cycles apart, no lost bits.
// - 8 bits spread with random data_val_i gaps -> single pulse after the 8th bit. Outputs hold between pulses.
// - 5 bits accepted, arst_i pulsed mid-cycle -> all outputs 0 immediately. The next 8 bits form a clean word with no leftover bits.
// - DESER_FLUSH_EN, MSB_FIRST=1, bits 1,1,1 then flush_i -> data_o=8'hE0, data_mod_o=3. flush_i when idle -> no pulse.
// - DESER_FLUSH_EN, flush_i with the 8th bit -> one pulse, data_mod_o=8. Without the macro, flush_i toggling has no effect.

Source files
------------

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler: gathers 1-bit samples into WIDTH-bit words.
// Optional partial-word flush is compiled in when DESER_FLUSH_EN is defined.
module serial_word_deserializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       data_i,
  input  logic                       data_val_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(WIDTH):0]     data_mod_o,
  output logic                       data_val_o,
  output logic                       busy_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  // Handshake: a bit is taken on every edge where data_val_i is high (no
  // backpressure); data_val_o is a one-cycle pulse qualifying data_o/data_mod_o.

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d, count_acc;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_acc;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    mod_q, mod_d;
  logic             val_q, val_d;
  logic             busy_q, busy_d;
  logic             full, flush_go, emit;

`ifndef DESER_FLUSH_EN
  logic unused_flush;
  assign unused_flush = flush_i;
`endif

  // Accumulated view of this cycle, including the bit accepted on this edge.
  always_comb begin
    count_acc = count_q + CW'(data_val_i);
    shreg_acc = shreg_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (data_val_i && (count_q == CW'(MSB_FIRST ? (WIDTH - 1 - i) : i))) begin
        shreg_acc[i] = data_i;
      end
    end
    full = (count_acc == CW'(WIDTH));
`ifdef DESER_FLUSH_EN
    flush_go = flush_i && (count_acc != '0);
`else
    flush_go = 1'b0;
`endif
    emit = full | flush_go;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (data_val_i && !emit) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (emit) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_acc;
    shreg_d = shreg_acc;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    if (emit) begin
      count_d = '0;
      shreg_d = '0;
      data_d  = shreg_acc;
      mod_d   = count_acc;
      val_d   = 1'b1;
    end
    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o     = data_q;
  assign data_mod_o = mod_q;
  assign data_val_o = val_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for serial_word_deserializer at WIDTH=8, both bit orders side by side.
// Flush scenarios depend on whether DESER_FLUSH_EN is defined for the build.
module tb_serial_word_deserializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         arst = 1'b0;
  logic         din = 1'b0;
  logic         dval = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] m_data, l_data;
  logic [3:0]   m_mod, l_mod;
  logic         m_val, l_val, m_busy, l_busy;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk), .arst_i(arst), .data_i(din), .data_val_i(dval), .flush_i(flush),
    .data_o(m_data), .data_mod_o(m_mod), .data_val_o(m_val), .busy_o(m_busy)
  );

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk), .arst_i(arst), .data_i(din), .data_val_i(dval), .flush_i(flush),
    .data_o(l_data), .data_mod_o(l_mod), .data_val_o(l_val), .busy_o(l_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of inputs at the falling edge, then sample 1ns after the rising edge.
  task automatic step(input logic v, input logic b, input logic f);
    @(negedge clk);
    dval = v; din = b; flush = f;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string name, input logic [W-1:0] em, input logic [W-1:0] el,
                          input logic [3:0] emod, input logic eval);
    checks++;
    if (m_data !== em || m_mod !== emod || m_val !== eval) begin
      errors++;
      $display("FAIL %s msb: data=%h mod=%0d val=%b, expected data=%h mod=%0d val=%b",
               name, m_data, m_mod, m_val, em, emod, eval);
    end
    checks++;
    if (l_data !== el || l_mod !== emod || l_val !== eval) begin
      errors++;
      $display("FAIL %s lsb: data=%h mod=%0d val=%b, expected data=%h mod=%0d val=%b",
               name, l_data, l_mod, l_val, el, emod, eval);
    end
  endtask

  task automatic test_reset;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #2 arst = 1'b0;
    #1;
    chk_word("reset", 8'h00, 8'h00, 4'd0, 1'b0);
    checks++;
    if (m_busy !== 1'b0 || l_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b/%b, expected 0/0", m_busy, l_busy);
    end
  endtask

  task automatic test_single_word;
    logic [W-1:0] w;
    w = 8'hB2;
    for (int i = 0; i < W; i++) begin
      step(1'b1, w[W-1-i], 1'b0);
      if (i < W - 1) begin
        checks++;
        if (m_val !== 1'b0 || m_busy !== 1'b1 || l_val !== 1'b0 || l_busy !== 1'b1) begin
          errors++;
          $display("FAIL single_mid bit %0d: val=%b%b busy=%b%b, expected val=00 busy=11",
                   i, m_val, l_val, m_busy, l_busy);
        end
      end
    end
    chk_word("single_emit", 8'hB2, 8'h4D, 4'd8, 1'b1);
    checks++;
    if (m_busy !== 1'b0 || l_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy: got %b/%b, expected 0/0", m_busy, l_busy);
    end
    step(1'b0, 1'b0, 1'b0);
    chk_word("single_hold", 8'hB2, 8'h4D, 4'd8, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] mw[3];
    logic [W-1:0] lw[3];
    int           last_cyc;
    int           pulses;
    mw[0] = 8'h96; lw[0] = 8'h69;
    mw[1] = 8'h3C; lw[1] = 8'h3C;
    mw[2] = 8'hC1; lw[2] = 8'h83;
    last_cyc = -1;
    pulses = 0;
    for (int i = 0; i < 3 * W; i++) begin
      step(1'b1, mw[i / W][W-1-(i % W)], 1'b0);
      checks++;
      if (m_val !== ((i % W) == W - 1) || l_val !== m_val) begin
        errors++;
        $display("FAIL b2b_pulse bit %0d: val=%b%b, expected %b", i, m_val, l_val,
                 ((i % W) == W - 1));
      end
      if ((i % W) == W - 1) begin
        chk_word("b2b_word", mw[i / W], lw[i / W], 4'd8, 1'b1);
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != W) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles, expected %0d", cyc - last_cyc, W);
          end
        end
        last_cyc = cyc;
      end
      if (m_val === 1'b1) pulses++;
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (pulses != 3 || m_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d busy=%b, expected 3 and 0", pulses, m_busy);
    end
  endtask

  task automatic test_gaps;
    logic [W-1:0] w;
    w = 8'hD1;
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        chk_word("gap_hold", 8'hC1, 8'h83, 4'd8, 1'b0);
      end
      step(1'b1, w[W-1-i], 1'b0);
      if (i < W - 1) chk_word("gap_bit_hold", 8'hC1, 8'h83, 4'd8, 1'b0);
    end
    chk_word("gap_emit", 8'hD1, 8'h8B, 4'd8, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_word("gap_after", 8'hD1, 8'h8B, 4'd8, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] w;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    #2 arst = 1'b1;
    #1;
    chk_word("rst_mid_out", 8'h00, 8'h00, 4'd0, 1'b0);
    checks++;
    if (m_busy !== 1'b0 || l_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: got %b/%b, expected 0/0", m_busy, l_busy);
    end
    arst = 1'b0;
    w = 8'h73;
    for (int i = 0; i < W; i++) step(1'b1, w[W-1-i], 1'b0);
    chk_word("rst_clean_word", 8'h73, 8'hCE, 4'd8, 1'b1);
    // Reset landing inside the output pulse must kill it.
    #2 arst = 1'b1;
    #1;
    chk_word("rst_kill_pulse", 8'h00, 8'h00, 4'd0, 1'b0);
    arst = 1'b0;
  endtask

`ifdef DESER_FLUSH_EN
  task automatic test_flush;
    logic [W-1:0] w;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk_word("flush_partial", 8'hE0, 8'h07, 4'd3, 1'b1);
    checks++;
    if (m_busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: got %b, expected 0", m_busy);
    end
    step(1'b0, 1'b0, 1'b1);
    chk_word("flush_idle", 8'hE0, 8'h07, 4'd3, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk_word("flush_one_bit", 8'h80, 8'h01, 4'd1, 1'b1);
    w = 8'h55;
    for (int i = 0; i < W; i++) step(1'b1, w[W-1-i], (i == W - 1));
    chk_word("flush_full", 8'h55, 8'hAA, 4'd8, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk_word("flush_full_once", 8'h55, 8'hAA, 4'd8, 1'b0);
  endtask
`else
  task automatic test_flush_ignored;
    logic [W-1:0] w;
    step(1'b0, 1'b0, 1'b1);
    chk_word("noflush_idle", 8'h00, 8'h00, 4'd0, 1'b0);
    w = 8'h55;
    for (int i = 0; i < W; i++) begin
      step(1'b1, w[W-1-i], 1'(i % 2));
      if (i < W - 1) begin
        chk_word("noflush_mid", 8'h00, 8'h00, 4'd0, 1'b0);
        checks++;
        if (m_busy !== 1'b1) begin
          errors++;
          $display("FAIL noflush_busy bit %0d: got %b, expected 1", i, m_busy);
        end
      end
    end
    chk_word("noflush_full", 8'h55, 8'hAA, 4'd8, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk_word("noflush_after", 8'h55, 8'hAA, 4'd8, 1'b0);
  endtask
`endif

  initial begin
    test_reset;
    test_single_word;
    test_back_to_back;
    test_gaps;
    test_reset_mid;
`ifdef DESER_FLUSH_EN
    test_flush;
`else
    test_flush_ignored;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
